// File: rtl/power_feature_extractor.sv
// Windowed power-trace feature extractor feeding the fuzzy attack detector.
// Emits energy, peak, mean and Hamming-distance features once per window.
module power_feature_extractor #(
  parameter int SAMPLE_W = 8,
  parameter int DATA_W   = 8,
  parameter int WIN_LOG2 = 4,
  parameter int ESHIFT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                win_clr,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [DATA_W-1:0]   data_word,
  output logic [9:0]          energy,
  output logic [9:0]          peak_power,
  output logic [9:0]          mean_power,
  output logic [7:0]          hamming_dist,
  output logic                feat_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  localparam int SUM_W = SAMPLE_W + WIN_LOG2;
  localparam int SQ_W  = 2 * SAMPLE_W + WIN_LOG2;
  localparam int HD_W  = DATA_W + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << WIN_LOG2) - 1);

  logic [1:0]          r_state;
  logic [SUM_W-1:0]    r_sum;
  logic [SQ_W-1:0]     r_sqsum;
  logic [SAMPLE_W-1:0] r_peak;
  logic [HD_W-1:0]     r_hd;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_prev;

  logic                w_acc;
  logic                w_clear;
  logic [HD_W-1:0]     w_pop;
  logic [SQ_W-1:0]     w_sq;
  logic [SQ_W-1:0]     w_esh;
  logic [SUM_W-1:0]    w_mean;
  logic [9:0]          w_energy;
  logic [9:0]          w_mean_sat;
  logic [7:0]          w_hd_sat;

  assign sample_ready = (r_state == S_ACCUM) && en;
  assign w_acc   = sample_ready && sample_valid && !win_clr;
  assign w_clear = (r_state == S_LATCH) ||
                   ((r_state == S_ACCUM) && (!en || win_clr));

  assign w_pop = HD_W'($countones(data_word ^ r_prev));
  assign w_sq  = SQ_W'(sample) * SQ_W'(sample);

  // Saturation is applied only when forming outputs; accumulators are lossless
  assign w_esh      = r_sqsum >> ESHIFT;
  assign w_mean     = r_sum >> WIN_LOG2;
  assign w_energy   = (w_esh > SQ_W'(1023)) ? 10'd1023 : w_esh[9:0];
  assign w_mean_sat = (w_mean > SUM_W'(1023)) ? 10'd1023 : w_mean[9:0];
  assign w_hd_sat   = (r_hd > HD_W'(255)) ? 8'hFF : r_hd[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_sqsum <= '0;
      r_peak  <= '0;
      r_hd    <= '0;
      r_cnt   <= '0;
      r_prev  <= '0;
    end else if (w_clear) begin
      r_sum   <= '0;
      r_sqsum <= '0;
      r_peak  <= '0;
      r_hd    <= '0;
      r_cnt   <= '0;
    end else if (w_acc) begin
      r_sum   <= r_sum + SUM_W'(sample);
      r_sqsum <= r_sqsum + w_sq;
      r_peak  <= (sample > r_peak) ? sample : r_peak;
      r_hd    <= r_hd + w_pop;
      r_cnt   <= r_cnt + 1'b1;
      r_prev  <= data_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      energy       <= '0;
      peak_power   <= '0;
      mean_power   <= '0;
      hamming_dist <= '0;
      feat_valid   <= 1'b0;
    end else begin
      feat_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (!en) r_state <= S_IDLE;
          else if (w_acc && (r_cnt == LAST)) r_state <= S_LATCH;
        end
        S_LATCH: begin
          if (win_clr) begin
            r_state <= S_ACCUM;
          end else begin
            energy       <= w_energy;
            peak_power   <= 10'(r_peak);
            mean_power   <= w_mean_sat;
            hamming_dist <= w_hd_sat;
            feat_valid   <= 1'b1;
            r_state      <= en ? S_ACCUM : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_power_feature_extractor.sv
// Bench for power_feature_extractor: directed window table, reset
// corner cases and a randomized run against a queue-based window model.
module tb_power_feature_extractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       win_clr = 1'b0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic [7:0] sample = '0;
  logic [7:0] data_word = '0;
  logic [9:0] energy;
  logic [9:0] peak_power;
  logic [9:0] mean_power;
  logic [7:0] hamming_dist;
  logic       feat_valid;

  power_feature_extractor dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .win_clr      (win_clr),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample       (sample),
    .data_word    (data_word),
    .energy       (energy),
    .peak_power   (peak_power),
    .mean_power   (mean_power),
    .hamming_dist (hamming_dist),
    .feat_valid   (feat_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Window model: 0 idle, 1 collecting, 2 one-cycle latch
  int m_mode;
  int q_s[$];
  int q_h[$];
  int m_prev;
  int e_en, e_pk, e_mn, e_hd;
  bit e_fv;
  bit m_acc;

  int cap_cnt = 0;
  int c_en, c_pk, c_mn, c_hd;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pop8(int x);
    int n = 0;
    for (int b = 0; b < 8; b++) n += (x >> b) & 1;
    return n;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    q_s.delete();
    q_h.delete();
    m_prev = 0;
    e_en = 0; e_pk = 0; e_mn = 0; e_hd = 0;
    e_fv = 0;
    m_acc = 0;
  endtask

  task automatic model_update();
    int s, sq, pk, hd;
    m_acc = 0;
    e_fv = 0;
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        if (!en) begin
          q_s.delete(); q_h.delete(); m_mode = 0;
        end else if (win_clr) begin
          q_s.delete(); q_h.delete();
        end else if (sample_valid) begin
          q_s.push_back(int'(sample));
          q_h.push_back(pop8(int'(data_word) ^ m_prev));
          m_prev = int'(data_word);
          m_acc = 1;
          if (q_s.size() == 16) m_mode = 2;
        end
      end
      default: begin
        if (win_clr) begin
          m_mode = 1;
        end else begin
          s = 0; sq = 0; pk = 0; hd = 0;
          foreach (q_s[i]) begin
            s += q_s[i];
            sq += q_s[i] * q_s[i];
            if (q_s[i] > pk) pk = q_s[i];
            hd += q_h[i];
          end
          e_en = (sq / 16 > 1023) ? 1023 : sq / 16;
          e_pk = pk;
          e_mn = s / 16;
          e_hd = (hd > 255) ? 255 : hd;
          e_fv = 1;
          m_mode = en ? 1 : 0;
        end
        q_s.delete(); q_h.delete();
      end
    endcase
  endtask

  task automatic step();
    #1;
    chk("ready", int'(sample_ready), int'(m_mode == 1 && en));
    chk("feat_valid", int'(feat_valid), int'(e_fv));
    chk("energy", int'(energy), e_en);
    chk("peak", int'(peak_power), e_pk);
    chk("mean", int'(mean_power), e_mn);
    chk("ham", int'(hamming_dist), e_hd);
    if (feat_valid) begin
      cap_cnt++;
      c_en = int'(energy); c_pk = int'(peak_power);
      c_mn = int'(mean_power); c_hd = int'(hamming_dist);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic send(int s, int w);
    sample = 8'(s);
    data_word = 8'(w);
    sample_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (m_acc) begin
        sample_valid = 1'b0;
        return;
      end
    end
    sample_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout sample not accepted within 20 cycles t=%0t", $time);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ready", int'(sample_ready), 0);
    chk("rst_fvalid", int'(feat_valid), 0);
    chk("rst_energy", int'(energy), 0);
    chk("rst_peak", int'(peak_power), 0);
    chk("rst_mean", int'(mean_power), 0);
    chk("rst_ham", int'(hamming_dist), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_window(string name, int c0, int en_x, int pk_x,
                            int mn_x, int hd_x);
    chk({name, "_pulses"}, cap_cnt - c0, 1);
    chk({name, "_energy"}, c_en, en_x);
    chk({name, "_peak"}, c_pk, pk_x);
    chk({name, "_mean"}, c_mn, mn_x);
    chk({name, "_ham"}, c_hd, hd_x);
  endtask

  typedef struct {
    string name;
    bit    rst_first;
    int    smode;
    int    sval;
    int    wmode;
    int    gap;
    int    npre;
    int    x_en;
    int    x_pk;
    int    x_mn;
    int    x_hd;
  } vec_t;

  vec_t vecs[5];

  function automatic int wpat(int mode, int i);
    if (mode == 1) return (i % 2 == 1) ? 255 : 0;
    if (mode == 2) return (i % 2 == 0) ? 255 : 0;
    return 0;
  endfunction

  initial begin
    int c0;
    vecs[0] = '{"T1", 1, 0, 5,   0, 0, 0, 25,   5,   5,   0};
    vecs[1] = '{"T2", 0, 1, 0,   1, 0, 0, 77,   15,  7,   120};
    vecs[2] = '{"T3", 1, 0, 255, 2, 0, 0, 1023, 255, 255, 128};
    vecs[3] = '{"T4", 1, 0, 5,   0, 1, 0, 25,   5,   5,   0};
    vecs[4] = '{"T5", 1, 0, 3,   0, 0, 7, 9,    3,   3,   0};

    model_reset();
    @(negedge clk);
    do_reset();

    foreach (vecs[v]) begin
      if (vecs[v].rst_first) do_reset();
      en = 1'b1;
      c0 = cap_cnt;
      for (int i = 0; i < vecs[v].npre; i++) send(9, 0);
      if (vecs[v].npre > 0) begin
        sample = 8'd9;
        sample_valid = 1'b1;
        win_clr = 1'b1;
        step();
        win_clr = 1'b0;
        sample_valid = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
        send(vecs[v].smode == 1 ? i : vecs[v].sval, wpat(vecs[v].wmode, i));
        if (vecs[v].gap > 0 && i < 15)
          for (int g = 0; g < vecs[v].gap; g++) step();
      end
      if (vecs[v].gap > 0) send(vecs[v].sval, 0);
      for (int g = 0; g < 4; g++) step();
      chk_window(vecs[v].name, c0, vecs[v].x_en, vecs[v].x_pk,
                 vecs[v].x_mn, vecs[v].x_hd);
    end

    // Asynchronous reset mid-window, then a clean window
    c0 = cap_cnt;
    for (int i = 0; i < 10; i++) send(7, 3);
    #2;
    do_reset();
    for (int i = 0; i < 16; i++) send(5, 0);
    for (int g = 0; g < 4; g++) step();
    chk_window("T6", c0, 25, 5, 5, 0);

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 99) < 97);
      win_clr = ($urandom_range(0, 99) < 3);
      sample_valid = ($urandom_range(0, 99) < 60);
      sample = ($urandom_range(0, 99) < 20) ? 8'd255 : 8'($urandom_range(0, 255));
      data_word = 8'($urandom_range(0, 255));
      step();
    end
    en = 1'b0;
    win_clr = 1'b0;
    sample_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
